prm_oblgc_sched: RTL and testbench

- Sequences a bank of NUM_EDGE combinational obstacle-logic checkers, one checker per roadmap edge.
- All checkers share a registered 15-bit obstacle-voxel code (inputs A..O) and each returns one edge_mask bit.
- The block accepts a stream of voxel codes for one query and drives each code to the bank, one per cycle.
- It OR-accumulates the returned masks into a blocked-edge vector and hands that vector to the PRM graph-search logic with a valid/ready handshake.

---
 rtl/prm_oblgc_sched.sv | 114 +++++++++++
 tb/tb_prm_oblgc_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_oblgc_sched.sv
// Scheduler for a bank of PRM obstacle-logic checkers: streams voxel codes
// to the bank and OR-accumulates returned edge masks per query.
module prm_oblgc_sched #(
   parameter int CODE_W   = 15,
   parameter int NUM_EDGE = 64,
   parameter int CNT_W    = 16
) (
   input  logic                CLK,
   input  logic                RST_n,
   input  logic                abort,
   input  logic                obs_valid,
   output logic                obs_ready,
   input  logic [CODE_W-1:0]   obs_code,
   input  logic                obs_last,
   output logic [CODE_W-1:0]   chk_code,
   input  logic [NUM_EDGE-1:0] chk_mask,
   output logic                mask_valid,
   input  logic                mask_ready,
   output logic [NUM_EDGE-1:0] mask_out,
   output logic                all_blocked,
   output logic [CNT_W-1:0]    voxel_cnt,
   output logic                busy
);

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      DRAIN = 2'd1,
      OUT   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [NUM_EDGE-1:0] acc_q, acc_d;
   logic                all_blk_q, all_blk_d;
   logic                s1_v_q, s1_v_d;
   logic                s1_last_q, s1_last_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [NUM_EDGE-1:0] acc_fold;
   logic                accept;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q   <= ACC;
         acc_q     <= '0;
         all_blk_q <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_last_q <= 1'b0;
         code_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         all_blk_q <= all_blk_d;
         s1_v_q    <= s1_v_d;
         s1_last_q <= s1_last_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
      end
   end

   assign obs_ready = (state_q == ACC);
   assign accept    = obs_valid & obs_ready;
   assign acc_fold  = s1_v_q ? (acc_q | chk_mask) : acc_q;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_fold;
      s1_v_d    = 1'b0;
      s1_last_d = s1_last_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         ACC: begin
            if (accept) begin
               cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
               // once the fold saturates, further checks cannot change acc
               if (!(&acc_fold)) begin
                  code_d    = obs_code;
                  s1_v_d    = 1'b1;
                  s1_last_d = obs_last;
               end
               if (obs_last) state_d = DRAIN;
            end
         end
         DRAIN: state_d = OUT;
         OUT: begin
            if (mask_ready) begin
               state_d = ACC;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = ACC;
      endcase
      if (abort) begin
         state_d   = ACC;
         acc_d     = '0;
         s1_v_d    = 1'b0;
         s1_last_d = 1'b0;
         code_d    = code_q;
         cnt_d     = '0;
      end
      all_blk_d = &acc_d;
   end

   assign chk_code    = code_q;
   assign mask_valid  = (state_q == OUT);
   assign mask_out    = acc_q;
   assign all_blocked = all_blk_q;
   assign voxel_cnt   = cnt_q;
   assign busy        = (state_q != ACC) | (|acc_q) | s1_v_q;

endmodule

// File: tb/tb_prm_oblgc_sched.sv
// Bench for prm_oblgc_sched: directed scenarios plus randomized queries
// compared against an OR-of-masks query model.
module tb_prm_oblgc_sched;

   localparam int CODE_W   = 15;
   localparam int NUM_EDGE = 64;
   localparam int CNT_W    = 16;

   logic                CLK = 1'b0;
   logic                RST_n;
   logic                abort;
   logic                obs_valid;
   logic                obs_ready;
   logic [CODE_W-1:0]   obs_code;
   logic                obs_last;
   logic [CODE_W-1:0]   chk_code;
   logic [NUM_EDGE-1:0] chk_mask;
   logic                mask_valid;
   logic                mask_ready;
   logic [NUM_EDGE-1:0] mask_out;
   logic                all_blocked;
   logic [CNT_W-1:0]    voxel_cnt;
   logic                busy;

   int checks   = 0;
   int failures = 0;
   int mode     = 0;
   logic [NUM_EDGE-1:0] tbl [256];

   prm_oblgc_sched #(
      .CODE_W(CODE_W), .NUM_EDGE(NUM_EDGE), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .RST_n(RST_n), .abort(abort),
      .obs_valid(obs_valid), .obs_ready(obs_ready),
      .obs_code(obs_code), .obs_last(obs_last),
      .chk_code(chk_code), .chk_mask(chk_mask),
      .mask_valid(mask_valid), .mask_ready(mask_ready),
      .mask_out(mask_out), .all_blocked(all_blocked),
      .voxel_cnt(voxel_cnt), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // behavioural checker bank
   always_comb begin
      chk_mask = '0;
      case (mode)
         0: chk_mask = 64'd1 << chk_code[5:0];
         1: chk_mask = '1;
         default: chk_mask = tbl[chk_code[7:0]];
      endcase
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic handshake();
      mask_ready = 1'b1;
      step();
      mask_ready = 1'b0;
   endtask

   initial begin
      logic [CODE_W-1:0] c3 [5];
      logic [63:0] exp_m;
      int          len, i, guard, n;
      logic        hs, seen;

      RST_n = 1'b0; abort = 1'b0; obs_valid = 1'b0;
      obs_code = '0; obs_last = 1'b0; mask_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_ready", obs_ready, 1);
      check("rst_mv", mask_valid, 0);
      check("rst_allblk", all_blocked, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", voxel_cnt, 0);
      check("rst_code", chk_code, 0);
      check("rst_mask", mask_out, 0);
      #2 RST_n = 1'b1;
      step();

      // back-to-back query 3,10,3
      obs_valid = 1; obs_code = 3; obs_last = 0; step();
      obs_code = 10; step();
      obs_code = 3; obs_last = 1; step();
      obs_valid = 0; obs_last = 0;
      check("t1_mv_early", mask_valid, 0);
      check("t1_rdy_drain", obs_ready, 0);
      step();
      check("t1_mv", mask_valid, 1);
      check("t1_mask", mask_out, 64'h408);
      check("t1_cnt", voxel_cnt, 3);
      check("t1_busy", busy, 1);
      handshake();
      check("t1_clr", mask_out, 0);

      // single voxel with backpressure
      obs_valid = 1; obs_code = 15'h7FFF; obs_last = 1; step();
      obs_valid = 0; obs_last = 0; step();
      for (int k = 0; k < 5; k++) begin
         check("t2_mv_hold", mask_valid, 1);
         check("t2_mask_hold", mask_out, 64'h8000_0000_0000_0000);
         step();
      end
      handshake();
      check("t2_clr", mask_out, 0);
      check("t2_rdy", obs_ready, 1);
      check("t2_mv", mask_valid, 0);
      check("t2_busy", busy, 0);

      // saturating query
      mode = 1;
      c3[0] = 15'h111; c3[1] = 15'h222; c3[2] = 15'h333;
      c3[3] = 15'h444; c3[4] = 15'h555;
      obs_valid = 1;
      for (int k = 0; k < 5; k++) begin
         obs_code = c3[k]; obs_last = (k == 4);
         step();
         if (k == 0) check("t3_ab_pre", all_blocked, 0);
         if (k == 1) check("t3_ab", all_blocked, 1);
      end
      obs_valid = 0; obs_last = 0;
      check("t3_code", chk_code, 15'h111);
      step();
      check("t3_mv", mask_valid, 1);
      check("t3_cnt", voxel_cnt, 5);
      check("t3_mask", mask_out, '1);
      handshake();
      mode = 0;

      // abort mid-query
      obs_valid = 1; obs_last = 0;
      for (int k = 1; k <= 5; k++) begin
         obs_code = CODE_W'(k); step();
      end
      obs_valid = 0; abort = 1; step();
      abort = 0;
      check("t4_mask", mask_out, 0);
      check("t4_cnt", voxel_cnt, 0);
      check("t4_busy", busy, 0);
      check("t4_rdy", obs_ready, 1);
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         seen |= mask_valid; step();
      end
      check("t4_no_mv", seen, 0);
      obs_valid = 1; obs_code = 7; obs_last = 1; step();
      obs_valid = 0; obs_last = 0; step();
      check("t4_mv", mask_valid, 1);
      check("t4_mask7", mask_out, 64'h80);
      handshake();

      // async reset while in OUT
      obs_valid = 1; obs_code = 9; obs_last = 1; step();
      obs_valid = 0; obs_last = 0; step();
      check("t5_mv", mask_valid, 1);
      #2 RST_n = 1'b0;
      #1;
      check("t5_rst_mv", mask_valid, 0);
      check("t5_rst_rdy", obs_ready, 1);
      check("t5_rst_mask", mask_out, 0);
      check("t5_rst_cnt", voxel_cnt, 0);
      check("t5_rst_code", chk_code, 0);
      check("t5_rst_busy", busy, 0);
      @(negedge CLK);
      RST_n = 1'b1;
      step();

      // voxel held across the handshake edge
      obs_valid = 1; obs_code = 12; obs_last = 1; step();
      obs_valid = 0; step();
      check("t6_mv", mask_valid, 1);
      obs_valid = 1; obs_code = 20; obs_last = 1; mask_ready = 1;
      step();
      mask_ready = 0;
      check("t6_hs_cnt", voxel_cnt, 0);
      check("t6_hs_rdy", obs_ready, 1);
      step();
      obs_valid = 0; obs_last = 0;
      check("t6_acc_cnt", voxel_cnt, 1);
      check("t6_acc_code", chk_code, 20);
      step();
      check("t6_mv2", mask_valid, 1);
      check("t6_mask", mask_out, 64'h10_0000);
      handshake();

      // randomized queries against OR model
      for (int k = 0; k < 256; k++)
         tbl[k] = {$urandom, $urandom} & {$urandom, $urandom} &
                  {$urandom, $urandom} & {$urandom, $urandom};
      mode = 2;
      for (int q = 0; q < 1000; q++) begin
         len = $urandom_range(1, 40);
         exp_m = '0; i = 0; guard = 0;
         while (i < len && guard < 1000) begin
            obs_valid = ($urandom % 4) != 0;
            obs_code = CODE_W'($urandom);
            obs_last = (i == len - 1);
            if (obs_valid) check("rq_rdy_acc", obs_ready, 1);
            if (obs_valid && obs_ready) begin
               exp_m |= tbl[obs_code[7:0]];
               i++;
            end
            step();
            guard++;
         end
         obs_valid = 0; obs_last = 0;
         n = 0;
         while (!mask_valid && n < 4) begin
            check("rq_rdy_drain", obs_ready, 0);
            obs_valid = $urandom % 2; obs_code = CODE_W'($urandom);
            obs_last = 1;
            step();
            n++;
         end
         check("rq_mv", mask_valid, 1);
         check("rq_cnt", voxel_cnt, CNT_W'(len));
         check("rq_mask", mask_out, exp_m);
         check("rq_ab", all_blocked, (exp_m == '1));
         guard = 0;
         do begin
            mask_ready = $urandom % 2;
            obs_valid = $urandom % 2; obs_code = CODE_W'($urandom);
            obs_last = 1;
            check("rq_rdy_out", obs_ready, 0);
            check("rq_hold", mask_out, exp_m);
            hs = mask_ready;
            step();
            guard++;
         end while (!hs && guard < 200);
         check("rq_hs", hs, 1);
         mask_ready = 0; obs_valid = 0; obs_last = 0;
         check("rq_post_rdy", obs_ready, 1);
         check("rq_post_cnt", voxel_cnt, 0);
         check("rq_post_mask", mask_out, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
